// File: rtl/prio_enc_pkg.sv
// Shared default size and index-width helper for the priority-encoder block.
package prio_enc_pkg;

    localparam int DEFAULT_N = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(DEFAULT_N)-1:0] idx_t;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational encoder: index of the highest set bit of vec, plus a found flag.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0]              vec,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      found
);

    localparam int W = idx_width(N);

    // Ascending scan so the last hit, the highest index, wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_prio_enc.sv
// Registered priority encoder with valid/ready handshake.
// Define RR_PRIO_ENC_RR_EN for round-robin grant; otherwise highest index wins.
module rr_prio_enc
    import prio_enc_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              d,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [idx_width(N)-1:0]   a,
    output logic                      any,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int W = idx_width(N);

    logic          accept;
    logic [N-1:0]  enc_vec;
    logic [W-1:0]  hi_idx;
    logic          hi_found;
    logic [W-1:0]  grant;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    prio_enc_core #(.N(N)) u_core (
        .vec   (enc_vec),
        .idx   (hi_idx),
        .found (hi_found)
    );

`ifdef RR_PRIO_ENC_RR_EN
    logic [W-1:0] ptr;

    // Line (ptr+k) mod N lands at bit N-1-k, so the highest set bit of the
    // rotated vector is the first request at or above ptr.
    always_comb begin
        int s;
        enc_vec = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            enc_vec[N-1-k] = d[s];
        end
    end

    always_comb begin
        int s;
        s = int'(ptr) + (N - 1 - int'(hi_idx));
        if (s >= N) s = s - N;
        grant = W'(s);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && hi_found) begin
            ptr <= (grant == W'(N - 1)) ? '0 : grant + W'(1);
        end
    end
`else
    assign enc_vec = d;
    assign grant   = hi_idx;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a         <= '0;
            any       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a         <= hi_found ? grant : '0;
            any       <= hi_found;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_prio_enc.sv
// Directed bench for rr_prio_enc (N=8); expectations follow RR_PRIO_ENC_RR_EN.
module tb_rr_prio_enc;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] d;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   a;
    logic         any;
    logic         out_valid;
    logic         out_ready;

    int tests;
    int fails;

    rr_prio_enc #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .any       (any),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; d = 8'hFF; out_ready = 1'b0;
        tick();
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (a !== 3'd0) begin fails++; $display("FAIL reset_a got %0d want 0", a); end
        tests++; if (any !== 1'b0) begin fails++; $display("FAIL reset_any got %b want 0", any); end
        rst_n = 1'b1; in_valid = 1'b0; d = '0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

`ifdef RR_PRIO_ENC_RR_EN
    task automatic test_rr_sequence();
        out_ready = 1'b1; in_valid = 1'b1; d = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (a !== 3'(i % 8) || any !== 1'b1 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL rr_seq[%0d] got a=%0d any=%b ov=%b want a=%0d any=1 ov=1", i, a, any, out_valid, i % 8);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        // ptr is 1 here
        logic [7:0] vecs [3] = '{8'h04, 8'h00, 8'hFF};
        logic [2:0] exp_a [3] = '{3'd2, 3'd0, 3'd3};
        logic       exp_any [3] = '{1'b1, 1'b0, 1'b1};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = vecs[i];
            tick();
            tests++;
            if (a !== exp_a[i] || any !== exp_any[i] || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL zero[%0d] got a=%0d any=%b ov=%b want a=%0d any=%b ov=1", i, a, any, out_valid, exp_a[i], exp_any[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        // ptr is 4 here
        logic [7:0] vecs [3] = '{8'h40, 8'h03, 8'h03};
        logic [2:0] exp_a [3] = '{3'd6, 3'd0, 3'd1};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = vecs[i];
            tick();
            tests++;
            if (a !== exp_a[i] || any !== 1'b1) begin
                fails++;
                $display("FAIL wrap[%0d] got a=%0d any=%b want a=%0d any=1", i, a, any, exp_a[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask
`else
    task automatic test_fixed_patterns();
        logic [7:0] vecs [7] = '{8'b1000_0001, 8'h01, 8'h06, 8'h7F, 8'h10, 8'hFF, 8'h00};
        logic [2:0] exp_a [7] = '{3'd7, 3'd0, 3'd2, 3'd6, 3'd4, 3'd7, 3'd0};
        logic       exp_any [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d = vecs[i];
            tick();
            tests++;
            if (a !== exp_a[i] || any !== exp_any[i] || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL fixed[%0d] got a=%0d any=%b ov=%b want a=%0d any=%b ov=1", i, a, any, out_valid, exp_a[i], exp_any[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_backpressure();
        // Both modes grant 5 then 2 here (RR ptr is 2 on entry).
        out_ready = 1'b1; in_valid = 1'b1; d = 8'h20;
        tick();
        tests++; if (a !== 3'd5 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_first got a=%0d ov=%b want a=5 ov=1", a, out_valid); end
        out_ready = 1'b0; d = 8'h04;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0 || a !== 3'd5 || any !== 1'b1 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d] got rdy=%b a=%0d any=%b ov=%b want rdy=0 a=5 any=1 ov=1", i, in_ready, a, any, out_valid);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b want 1", in_ready); end
        tick();
        tests++; if (a !== 3'd2 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_load got a=%0d ov=%b want a=2 ov=1", a, out_valid); end
        in_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got ov=%b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_drain_rdy got %b want 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_after;
`ifdef RR_PRIO_ENC_RR_EN
        exp_after = 3'd0;
`else
        exp_after = 3'd7;
`endif
        out_ready = 1'b0; in_valid = 1'b1; d = 8'h80;
        tick();
        tests++; if (out_valid !== 1'b1 || a !== 3'd7) begin fails++; $display("FAIL rstmid_pre got a=%0d ov=%b want a=7 ov=1", a, out_valid); end
        rst_n = 1'b0; d = 8'hFF;
        tick();
        tests++;
        if (out_valid !== 1'b0 || a !== 3'd0 || any !== 1'b0) begin
            fails++;
            $display("FAIL rstmid got a=%0d any=%b ov=%b want a=0 any=0 ov=0", a, any, out_valid);
        end
        rst_n = 1'b1; out_ready = 1'b1; d = 8'hFF;
        tick();
        tests++; if (a !== exp_after || any !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_after got a=%0d any=%b ov=%b want a=%0d any=1 ov=1", a, any, out_valid, exp_after); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; d = '0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
`ifdef RR_PRIO_ENC_RR_EN
        test_rr_sequence();
        test_zero();
        test_wrap();
`else
        test_fixed_patterns();
`endif
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
